led_pulse_blinker: RTL
======================

# led_pulse_blinker

Output-side counterpart to the push-button debouncer. It takes single-clock event pulses, such as the debounced button pulse or a frame-captured strobe, and turns each one into a human-visible LED blink with a guaranteed on-time and off-gap. Events that arrive while a blink is in progress are counted and replayed as further blinks, so every event is visible. It sits between the control logic and the active-low board LED pins.

## Interface
- ON_CYCLES, 2_400_000, LED-on duration in clocks (100 ms at 24 MHz); must be ≥ 1.
- OFF_CYCLES, 2_400_000, minimum LED-off gap after each blink, in clocks; must be ≥ 1.
- CNT_W, 4, width of the pending-event counter; max queued events is 2^CNT_W − 1.
- i_clk  input  1  system clock; the only clock.
- i_rst  input  1  synchronous, active-high reset.
- i_pulse  input  1  event strobe, one clock wide per event; consecutive high cycles count as separate events.
- o_led_n  output  1  LED drive, active low, registered.
- o_busy  output  1  high while not IDLE or while the pending count is ≠ 0.
- o_overflow  output  1  one-clock pulse when an event is dropped, registered.

## Operation
- FSM states: IDLE, ON, OFF. A down-counting timer of width $clog2(max(ON_CYCLES, OFF_CYCLES) + 1) sets the length of ON and OFF.
- IDLE → ON when i_pulse = 1 or pending ≠ 0.
  - The timer loads ON_CYCLES − 1.
  - If the transition is triggered by pending alone, pending decrements.
  - If i_pulse = 1, that pulse itself is the event being consumed, and pending is unchanged.
- ON: o_led_n = 0. The timer decrements each cycle. At timer = 0, go to OFF and load OFF_CYCLES − 1.
- OFF: o_led_n = 1. At timer = 0:
  - if pending ≠ 0 or i_pulse = 1, go directly to ON, consuming the event with the same rules as IDLE;
  - otherwise go to IDLE.
- Queueing: i_pulse in ON, or in OFF on a cycle other than the terminal one, increments pending.
  - Increment and decrement in the same cycle leave pending unchanged.
  - An increment at pending = 2^CNT_W − 1 is dropped, and o_overflow = 1 on the next cycle.
- Arithmetic: pending is unsigned and never wraps; it saturates at both ends.
- Reset values: o_led_n = 1, o_busy = 0, o_overflow = 0, state IDLE, timer 0, pending 0.
- Reset mid-blink: on the cycle after i_rst is sampled high, o_led_n = 1 and pending is cleared. An i_pulse in a reset cycle is ignored.

## Timing
- Latency: i_pulse sampled at edge N gives o_led_n = 0 from edge N+1.
- Each blink is exactly ON_CYCLES cycles low, followed by exactly OFF_CYCLES cycles high.
- Back-to-back blinks have no extra IDLE cycle between them.
- o_busy is combinational from registers. It falls on the edge at which the FSM enters IDLE with pending = 0.
- o_overflow is high for exactly one cycle per dropped event.
- There is no handshake. i_pulse is never back-pressured.

## Configuration
- LED_BLINK_QUEUE_EN defined: the pending counter and replay behave as described above.
- LED_BLINK_QUEUE_EN undefined:
  - the pending counter is not built (CNT_W is ignored);
  - every i_pulse outside IDLE, and outside the terminal OFF cycle, is dropped and produces an o_overflow pulse;
  - o_busy = (state ≠ IDLE).

## Structure
- Shared package `led_pkg`: the state encoding typedef (IDLE/ON/OFF) and the default timing constants for a 24 MHz clock.
- Natural sub-module: `sat_counter`, a saturating up/down counter with an overflow flag, used for pending. It is instantiated only when LED_BLINK_QUEUE_EN is defined.
- The timer and FSM stay in the top module.

## Test plan
All scenarios use ON_CYCLES = 4, OFF_CYCLES = 3, CNT_W = 2, with the macro defined unless noted.
- Reset: hold i_rst for 3 cycles → o_led_n = 1, o_busy = 0, o_overflow = 0 throughout and after release.
- Single pulse at cycle 10 → o_led_n = 0 in cycles 11–14 and 1 in cycles 15–17; o_busy high in cycles 11–17, low from 18.
- Three pulses at cycles 12, 13, 16 → four blinks total, LED low in 11–14, 18–21, 25–28 and 32–35; no idle gap between them.
- Five pulses in cycles 12–16 (pending saturates at 3) → o_overflow = 1 at cycles 16 and 17; four blinks total.
- Pulse on the terminal OFF cycle (cycle 17) → LED low in 18–21; pending stays 0.
- i_rst at cycle 13 mid-ON with pending = 2 → o_led_n = 1 from cycle 14, then no further blinks.
- Macro undefined, pulses at 10 and 12 → one blink only; o_overflow = 1 at cycle 13.

Source files
------------

// File: rtl/led_pkg.sv
// led_pkg: shared blinker state encoding and default 24 MHz timing constants
package led_pkg;
  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
  localparam int CLK_HZ = 24_000_000;
  localparam int DEF_ON_CYCLES = CLK_HZ / 10;
  localparam int DEF_OFF_CYCLES = CLK_HZ / 10;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up/down counter; drop flags an increment lost at full scale
module sat_counter #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         drop
);
  assign drop = inc && !dec && (&count);
  always_ff @(posedge i_clk)
    if (i_rst) count <= '0;
    else if (inc && !dec && !(&count)) count <= count + W'(1);
    else if (dec && !inc && count != '0) count <= count - W'(1);
endmodule

// File: rtl/led_pulse_blinker.sv
// led_pulse_blinker: stretches event pulses into ON/OFF LED blinks; LED_BLINK_QUEUE_EN replays events seen mid-blink
module led_pulse_blinker
  import led_pkg::*;
#(
  parameter int ON_CYCLES = DEF_ON_CYCLES,
  parameter int OFF_CYCLES = DEF_OFF_CYCLES,
  parameter int CNT_W = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pulse,
  output logic o_led_n,
  output logic o_busy,
  output logic o_overflow
);
  localparam int MAX_C = ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES;
  localparam int TW = $clog2(MAX_C + 1);
  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic free, start, enq, pend_nz, drop, on_done;
`ifdef LED_BLINK_QUEUE_EN
  logic [CNT_W-1:0] pending;
  sat_counter #(.W(CNT_W)) u_pending (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .inc(enq),
    .dec(start && !i_pulse),
    .count(pending),
    .drop(drop)
  );
  assign pend_nz = |pending;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = CNT_W > 0;
  assign pend_nz = 1'b0;
  assign drop = enq;
`endif
  // free: the FSM may begin a new blink this cycle (idle or last OFF cycle)
  always_comb begin
    free = state == IDLE || (state == OFF && timer == '0);
    on_done = state == ON && timer == '0;
    start = free && (i_pulse || pend_nz);
    enq = i_pulse && !free;
    state_n = start ? ON : on_done ? OFF : free ? IDLE : state;
    timer_n = start ? TW'(ON_CYCLES - 1) : on_done ? TW'(OFF_CYCLES - 1) :
              (timer == '0) ? timer : timer - TW'(1);
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= IDLE;
      timer <= '0;
      o_led_n <= 1'b1;
      o_overflow <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      o_led_n <= state_n != ON;
      o_overflow <= drop;
    end
  assign o_busy = state != IDLE || pend_nz;
endmodule
